// File: rtl/decoder_3x8.sv
// decoder_3x8: registered 3-to-8 one-hot decoder with active-high enable.
// Select index is {a,b,c} with a as MSB. Outputs change one clock after the
// inputs are sampled; there is no combinational input-to-output path.
// Optional build macro: DECODER_HOLD_EN -- when defined, a disabled cycle
// holds y/vld/idx instead of clearing y and vld.
module decoder_3x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] y,
    output logic       vld,
    output logic [2:0] idx
);

    logic [2:0] sel;
    logic [7:0] dec_onehot;

    logic [7:0] y_reg;
    logic [7:0] y_next;
    logic       vld_reg;
    logic       vld_next;
    logic [2:0] idx_reg;
    logic [2:0] idx_next;

    assign sel = {a, b, c};

    // One comparator per output line; exactly one matches any select value,
    // so the decode is one-hot by construction.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign dec_onehot[gi] = (sel == 3'(gi));
        end
    endgenerate

    // Next-state selection: an enabled cycle fully replaces the outputs,
    // a disabled cycle clears (default) or holds (DECODER_HOLD_EN).
    always_comb begin
        y_next   = y_reg;
        vld_next = vld_reg;
        idx_next = idx_reg;
        if (en) begin
            y_next   = dec_onehot;
            vld_next = 1'b1;
            idx_next = sel;
        end else begin
`ifdef DECODER_HOLD_EN
            y_next   = y_reg;
            vld_next = vld_reg;
`else
            y_next   = 8'h00;
            vld_next = 1'b0;
`endif
        end
    end

    // Output registers; reset takes priority over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_reg   <= 8'h00;
            vld_reg <= 1'b0;
            idx_reg <= 3'b000;
        end else begin
            y_reg   <= y_next;
            vld_reg <= vld_next;
            idx_reg <= idx_next;
        end
    end

    assign y   = y_reg;
    assign vld = vld_reg;
    assign idx = idx_reg;

endmodule

// File: tb/tb_decoder_3x8.sv
// Testbench for decoder_3x8: directed reset/sweep/disable/reset-priority
// sequences followed by randomized traffic, all checked against a
// transaction-level model of the decoder kept in this file.
// Honors DECODER_HOLD_EN the same way the design does.
module tb_decoder_3x8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       a;
    logic       b;
    logic       c;
    logic [7:0] y;
    logic       vld;
    logic [2:0] idx;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference model state: what the outputs should be after the last edge.
    logic [7:0] m_y;
    logic       m_vld;
    logic [2:0] m_idx;

    decoder_3x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .b     (b),
        .c     (c),
        .y     (y),
        .vld   (vld),
        .idx   (idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by one edge, then compare
    // all outputs 1 time unit after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] s);
        rst_n = r;
        en    = e;
        {a, b, c} = s;
        @(posedge clk);
        if (!r) begin
            m_y   = 8'h00;
            m_vld = 1'b0;
            m_idx = 3'd0;
        end else if (e) begin
            m_y   = 8'(2 ** int'(s));
            m_vld = 1'b1;
            m_idx = s;
        end else begin
`ifndef DECODER_HOLD_EN
            m_y   = 8'h00;
            m_vld = 1'b0;
`endif
        end
        #1;
        n_txn++;
        $display("txn %0d: rst_n=%0b en=%0b sel=%0d -> y=%02h vld=%0b idx=%0d (model y=%02h vld=%0b idx=%0d)",
                 n_txn, r, e, s, y, vld, idx, m_y, m_vld, m_idx);
        check("model_y", y, m_y);
        check("model_vld", vld, m_vld);
        check("model_idx", idx, m_idx);
        check("onehot", ($countones(y) <= 1), 1);
        check("vld_iff_nonzero", vld, (y != 8'h00));
    endtask

    initial begin
        logic [7:0] sweep_exp [8];
        sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        rst_n = 1'b0;
        en    = 1'b0;
        {a, b, c} = 3'b000;
        m_y   = 8'h00;
        m_vld = 1'b0;
        m_idx = 3'd0;

        // 1: reset held two cycles while enabled with select 101.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 3'b101);
            check("rst_y", y, 8'h00);
            check("rst_vld", vld, 1'b0);
            check("rst_idx", idx, 3'd0);
        end

        // 2: enabled sweep over every select value.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 3'(i));
            check("sweep_y", y, sweep_exp[i]);
            check("sweep_idx", idx, i);
            check("sweep_vld", vld, 1'b1);
        end

        // 3: enabled 011, then disabled with 110 on the select lines.
        step(1'b1, 1'b1, 3'b011);
        check("dis_pre_y", y, 8'h08);
        step(1'b1, 1'b0, 3'b110);
`ifdef DECODER_HOLD_EN
        check("dis_y", y, 8'h08);
        check("dis_vld", vld, 1'b1);
`else
        check("dis_y", y, 8'h00);
        check("dis_vld", vld, 1'b0);
`endif
        check("dis_idx", idx, 3'b011);

        // 4: enabled 111, then reset with enable still high.
        step(1'b1, 1'b1, 3'b111);
        check("rstmid_pre_y", y, 8'h80);
        step(1'b0, 1'b1, 3'b111);
        check("rstmid_y", y, 8'h00);
        check("rstmid_vld", vld, 1'b0);
        check("rstmid_idx", idx, 3'd0);

        // 5: random traffic with occasional resets.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 39) != 0), 1'($urandom), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
